// File: rtl/obi_pkg.sv
// ---------------------------------------------------------------------------
// obi_pkg
// Shared OBI definitions for the data-bus demultiplexer and its helpers.
//   OBI_AW / OBI_DW : address and data width of the data bus
//   obi_req_t       : host-side request bundle (req, we, be, addr, wdata)
//   obi_rsp_t       : host-side response bundle (gnt, rvalid, err, rdata)
//   addr_rule_t     : one address region (base, mask)
//   addr_match()    : true when an address falls inside a region
// ---------------------------------------------------------------------------
package obi_pkg;

    localparam int OBI_AW = 32;
    localparam int OBI_DW = 32;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [3:0]        be;
        logic [OBI_AW-1:0] addr;
        logic [OBI_DW-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic              err;
        logic [OBI_DW-1:0] rdata;
    } obi_rsp_t;

    typedef struct packed {
        logic [OBI_AW-1:0] base;
        logic [OBI_AW-1:0] mask;
    } addr_rule_t;

    // A region matches when the masked address equals the region base.
    function automatic logic addr_match(input logic [OBI_AW-1:0] addr,
                                        input addr_rule_t        rule);
        return (addr & rule.mask) == rule.base;
    endfunction

endpackage

// File: rtl/obi_err_slave.sv
// ---------------------------------------------------------------------------
// obi_err_slave
// Single-cycle error responder used for addresses that hit no region.
// Every accepted request is answered exactly one cycle later with err=1 and
// rdata=0, so back-to-back accepts give back-to-back responses.
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   accept_i      : an unmapped request was accepted this cycle
//   rvalid_o      : error response valid (registered)
//   err_o         : error flag of the response
//   rdata_o       : read data of the response (always zero)
// ---------------------------------------------------------------------------
module obi_err_slave
    import obi_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              accept_i,
    output logic              rvalid_o,
    output logic              err_o,
    output logic [OBI_DW-1:0] rdata_o
);

    logic err_rvalid;

    // The response simply follows the accept by one cycle; no further state
    // is needed because the demux never lets more than one source own the
    // outstanding responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_rvalid <= 1'b0;
        end else begin
            err_rvalid <= accept_i;
        end
    end

    assign rvalid_o = err_rvalid;
    assign err_o    = err_rvalid;
    assign rdata_o  = '0;

endmodule

// File: rtl/obi_data_demux.sv
// ---------------------------------------------------------------------------
// obi_data_demux
// OBI data-bus demultiplexer between the core data port and NUM_TARGETS
// memory-mapped targets. Requests are routed by address region; responses
// return in order because a request to a different target is held off until
// every outstanding response of the current target has come back. Addresses
// that match no region are answered by an internal error responder.
// Ports:
//   clk_i, rst_ni        : clock and asynchronous active-low reset
//   host_req_i/we/addr/wdata/be : host request channel
//   host_gnt_o           : grant to the host (combinational)
//   host_rvalid_o/err_o/rdata_o : host response channel (combinational mux)
//   tgt_req_o            : one-hot request to the selected target
//   tgt_addr_o/wdata_o/be_o/we_o : request fields broadcast to all targets
//   tgt_gnt_i/rvalid_i/err_i     : per-target grant and response flags
//   tgt_rdata_i          : per-target read data, target i at [i*32 +: 32]
// ---------------------------------------------------------------------------
module obi_data_demux
    import obi_pkg::*;
#(
    parameter int          NUM_TARGETS     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] ADDR_BASE [NUM_TARGETS] =
        '{32'h0200_0000, 32'h1000_0000, 32'h1A11_0000, 32'h2000_0000},
    parameter logic [31:0] ADDR_MASK [NUM_TARGETS] =
        '{32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000}
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic                          host_req_i,
    input  logic                          host_we_i,
    input  logic [OBI_AW-1:0]             host_addr_i,
    input  logic [OBI_DW-1:0]             host_wdata_i,
    input  logic [3:0]                    host_be_i,
    output logic                          host_gnt_o,
    output logic                          host_rvalid_o,
    output logic                          host_err_o,
    output logic [OBI_DW-1:0]             host_rdata_o,

    output logic [NUM_TARGETS-1:0]        tgt_req_o,
    output logic [OBI_AW-1:0]             tgt_addr_o,
    output logic [OBI_DW-1:0]             tgt_wdata_o,
    output logic [3:0]                    tgt_be_o,
    output logic                          tgt_we_o,
    input  logic [NUM_TARGETS-1:0]        tgt_gnt_i,
    input  logic [NUM_TARGETS-1:0]        tgt_rvalid_i,
    input  logic [NUM_TARGETS-1:0]        tgt_err_i,
    input  logic [NUM_TARGETS*OBI_DW-1:0] tgt_rdata_i
);

    localparam int               SEL_W   = $clog2(NUM_TARGETS + 1);
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [SEL_W-1:0] ERR_SEL = SEL_W'(NUM_TARGETS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    obi_req_t         host_req;
    obi_rsp_t         host_rsp;
    addr_rule_t       rules [NUM_TARGETS];

    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] cur_sel;
    logic [CNT_W-1:0] cnt;
    logic             stall;
    logic             sel_gnt;
    logic             accept;
    logic             err_accept;

    logic             err_rvalid;
    logic             err_err;
    logic [OBI_DW-1:0] err_rdata;

    logic             src_valid;
    logic             src_err;
    logic [OBI_DW-1:0] src_rdata;
    logic [NUM_TARGETS-1:0] own_mask;

    assign host_req = '{req:   host_req_i,
                        we:    host_we_i,
                        be:    host_be_i,
                        addr:  host_addr_i,
                        wdata: host_wdata_i};

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_rules
        assign rules[g] = '{base: ADDR_BASE[g], mask: ADDR_MASK[g]};
    end

    // Address decode: walking from the top index down lets the lowest
    // matching region win when regions overlap.
    always_comb begin
        sel = ERR_SEL;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (addr_match(host_req.addr, rules[i])) begin
                sel = SEL_W'(i);
            end
        end
    end

    // Hold off a request while the outstanding window is full, or while it
    // would go to a different source than the one still owing responses.
    assign stall = host_req.req &&
                   ((cnt == CNT_MAX) || ((cnt != '0) && (sel != cur_sel)));

    // Request routing and response muxing. The error responder grants
    // unconditionally; the response is gated by an outstanding transaction
    // so late or stray target responses never reach the host.
    always_comb begin
        tgt_req_o = '0;
        sel_gnt   = 1'b1;
        src_valid = 1'b0;
        src_err   = 1'b0;
        src_rdata = '0;
        own_mask  = '0;
        host_rsp  = '0;

        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (sel == SEL_W'(i)) begin
                tgt_req_o[i] = host_req.req && !stall;
                sel_gnt      = tgt_gnt_i[i];
            end
            if (cur_sel == SEL_W'(i)) begin
                src_valid   = tgt_rvalid_i[i];
                src_err     = tgt_err_i[i];
                src_rdata   = tgt_rdata_i[i*OBI_DW +: OBI_DW];
                own_mask[i] = 1'b1;
            end
        end

        if (cur_sel == ERR_SEL) begin
            src_valid = err_rvalid;
            src_err   = err_err;
            src_rdata = err_rdata;
        end

        host_rsp.gnt    = !stall && sel_gnt;
        host_rsp.rvalid = src_valid && (cnt != '0);
        host_rsp.err    = host_rsp.rvalid && src_err;
        host_rsp.rdata  = host_rsp.rvalid ? src_rdata : '0;
    end

    assign host_gnt_o    = host_rsp.gnt;
    assign host_rvalid_o = host_rsp.rvalid;
    assign host_err_o    = host_rsp.err;
    assign host_rdata_o  = host_rsp.rdata;

    assign tgt_addr_o  = host_req.addr;
    assign tgt_wdata_o = host_req.wdata;
    assign tgt_be_o    = host_req.be;
    assign tgt_we_o    = host_req.we;

    assign accept     = host_req.req && host_rsp.gnt;
    assign err_accept = accept && (sel == ERR_SEL);

    // Outstanding counter and owner. An accept together with a response
    // leaves the count unchanged; the count cannot overflow because a full
    // window stalls, and cannot underflow because rvalid is gated by cnt!=0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt     <= '0;
            cur_sel <= '0;
        end else begin
            if (accept) begin
                cur_sel <= sel;
            end
            if (accept && !host_rsp.rvalid) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!accept && host_rsp.rvalid) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    obi_err_slave u_err_slave (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .accept_i (err_accept),
        .rvalid_o (err_rvalid),
        .err_o    (err_err),
        .rdata_o  (err_rdata)
    );

    // Target protocol checks. Offending responses are already dropped by the
    // response mux; these only make the misbehaving target visible.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ((tgt_rvalid_i & ~own_mask) == '0)
                else $warning("obi_data_demux: rvalid from a target not owning the bus, dropped");
            assert (!((|tgt_rvalid_i) && (cnt == '0)))
                else $warning("obi_data_demux: rvalid with no outstanding transaction, dropped");
        end
    end

endmodule
